// File: rtl/reg_desloc_n.sv
// Shift/rotate/load register with an optional counted right-shift burst.
// The burst FSM and its counter exist only when REG_DESLOC_BURST_EN is defined.
module reg_desloc_n #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [2:0]               op,
    input  logic                     serial_in,
    input  logic [WIDTH-1:0]         parallel_in,
    input  logic [$clog2(WIDTH):0]   burst_len,
    output logic [WIDTH-1:0]         out,
    output logic                     serial_out,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] out_nxt;

    // Single-cycle operations; op 111 falls through to hold here.
    always_comb begin
        op_res = out;
        case (op)
            3'b001:  op_res = {serial_in, out[WIDTH-1:1]};
            3'b010:  op_res = {out[WIDTH-2:0], serial_in};
            3'b011:  op_res = parallel_in;
            3'b100:  op_res = {out[0], out[WIDTH-1:1]};
            3'b101:  op_res = {out[WIDTH-2:0], out[WIDTH-1]};
            3'b110:  op_res = {out[WIDTH-1], out[WIDTH-1:1]};
            default: op_res = out;
        endcase
    end

    assign serial_out = out[0];

`ifdef REG_DESLOC_BURST_EN

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out;
        done_nxt  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (op == 3'b111) begin
                        if (burst_len != '0) begin
                            state_nxt = BURST;
                            cnt_nxt   = burst_len;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else begin
                        out_nxt = op_res;
                    end
                end
                BURST: begin
                    out_nxt = {serial_in, out[WIDTH-1:1]};
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // done is a pulse: it clears on the next edge even if en drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            out   <= RESET_VAL;
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            out   <= out_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == BURST);

`else

    logic unused_burst_len;

    assign unused_burst_len = ^burst_len;
    assign out_nxt          = en ? op_res : out;
    assign busy             = 1'b0;
    assign done             = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_VAL;
        end else begin
            out <= out_nxt;
        end
    end

`endif

endmodule

// File: tb/tb_reg_desloc_n.sv
// Self-checking bench for reg_desloc_n (WIDTH=8); expectations follow the
// build's REG_DESLOC_BURST_EN setting.
module tb_reg_desloc_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] op;
    logic       serial_in;
    logic [7:0] parallel_in;
    logic [3:0] burst_len;
    logic [7:0] out;
    logic       serial_out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Behavioural model: register value, shifts remaining, done pulse.
    logic [7:0] m_out;
    int         m_rem;
    logic       m_done;

    reg_desloc_n #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .op          (op),
        .serial_in   (serial_in),
        .parallel_in (parallel_in),
        .burst_len   (burst_len),
        .out         (out),
        .serial_out  (serial_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_out  = 8'h00;
            m_rem  = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (en) begin
                if (m_rem > 0) begin
                    m_out = (m_out >> 1) | (serial_in ? 8'h80 : 8'h00);
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_done = 1'b1;
                end else begin
                    case (op)
                        3'd1: m_out = (m_out >> 1) | (serial_in ? 8'h80 : 8'h00);
                        3'd2: m_out = (m_out << 1) | (serial_in ? 8'h01 : 8'h00);
                        3'd3: m_out = parallel_in;
                        3'd4: m_out = (m_out >> 1) | (m_out << 7);
                        3'd5: m_out = (m_out << 1) | (m_out >> 7);
                        3'd6: m_out = (m_out >> 1) | (m_out & 8'h80);
                        3'd7: begin
`ifdef REG_DESLOC_BURST_EN
                            if (burst_len == 0) m_done = 1'b1;
                            else m_rem = int'(burst_len);
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (out !== m_out) begin
                failures++;
                $display("FAIL model_out t=%0t actual=%h required=%h", $time, out, m_out);
            end
            checks++;
            if (serial_out !== m_out[0]) begin
                failures++;
                $display("FAIL model_serial_out t=%0t actual=%b required=%b", $time, serial_out, m_out[0]);
            end
            checks++;
            if (busy !== (m_rem > 0)) begin
                failures++;
                $display("FAIL model_busy t=%0t actual=%b required=%b", $time, busy, m_rem > 0);
            end
            checks++;
            if (done !== m_done) begin
                failures++;
                $display("FAIL model_done t=%0t actual=%b required=%b", $time, done, m_done);
            end
        end
    end

    task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] o, input logic si, input logic [7:0] pi, input logic [3:0] bl);
        op = o; serial_in = si; parallel_in = pi; burst_len = bl;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1;
        drive(3'd0, 1'b0, 8'h00, 4'd0);
        step();
        chk_on = 1'b1;
        lit("reset_out", out, 8'h00);
        lit("reset_busy", {7'd0, busy}, 8'h00);
        lit("reset_done", {7'd0, done}, 8'h00);
        lit("reset_serial_out", {7'd0, serial_out}, 8'h00);
        reset = 1'b0;

        drive(3'd3, 1'b0, 8'hA5, 4'd0); step(); lit("load_a5", out, 8'hA5);
        drive(3'd4, 1'b0, 8'h00, 4'd0); step(); lit("rotr", out, 8'hD2);
        drive(3'd5, 1'b0, 8'h00, 4'd0); step(); lit("rotl", out, 8'hA5);
        drive(3'd3, 1'b0, 8'h80, 4'd0); step();
        drive(3'd6, 1'b0, 8'h00, 4'd0); step(); step(); lit("asr_x2", out, 8'hE0);

        drive(3'd3, 1'b0, 8'h00, 4'd0); step();
        drive(3'd2, 1'b1, 8'h00, 4'd0); step(); step(); step(); lit("shl_x3", out, 8'h07);
        en = 1'b0; step(); step(); lit("en_low_hold", out, 8'h07);
        en = 1'b1;
        drive(3'd1, 1'b0, 8'h00, 4'd0); step();
        lit("shr", out, 8'h03);
        lit("shr_serial_out", {7'd0, serial_out}, 8'h01);

        // Burst of 3 with op changes ignored while busy.
        drive(3'd3, 1'b0, 8'hF0, 4'd0); step();
        drive(3'd7, 1'b0, 8'h00, 4'd3); step();
`ifdef REG_DESLOC_BURST_EN
        lit("burst_start_out", out, 8'hF0);
        lit("burst_start_busy", {7'd0, busy}, 8'h01);
        drive(3'd3, 1'b0, 8'hFF, 4'd9); step(); lit("burst_1", out, 8'h78);
        drive(3'd4, 1'b0, 8'hFF, 4'd9); step(); lit("burst_2", out, 8'h3C);
        drive(3'd5, 1'b0, 8'hFF, 4'd9); step(); lit("burst_3", out, 8'h1E);
        lit("burst_done", {7'd0, done}, 8'h01);
        lit("burst_end_busy", {7'd0, busy}, 8'h00);
        // Back-to-back burst started on the done cycle.
        drive(3'd7, 1'b1, 8'h00, 4'd1); step(); lit("b2b_busy", {7'd0, busy}, 8'h01);
        drive(3'd0, 1'b1, 8'h00, 4'd0); step(); lit("b2b_out", out, 8'h8F);
        lit("b2b_done", {7'd0, done}, 8'h01);
`else
        lit("nb_op7_hold", out, 8'hF0);
`endif

        // Reset mid-burst aborts without done.
        drive(3'd3, 1'b0, 8'hFF, 4'd0); step();
        drive(3'd7, 1'b0, 8'h00, 4'd5); step();
        drive(3'd0, 1'b0, 8'h00, 4'd0); step(); step();
        reset = 1'b1; step();
        lit("abort_out", out, 8'h00);
        lit("abort_busy", {7'd0, busy}, 8'h00);
        lit("abort_done", {7'd0, done}, 8'h00);
        reset = 1'b0; step();
        lit("abort_no_done", {7'd0, done}, 8'h00);

        // Zero-length burst.
        drive(3'd3, 1'b0, 8'h5A, 4'd0); step();
        drive(3'd7, 1'b0, 8'h00, 4'd0); step();
        lit("zero_len_out", out, 8'h5A);
`ifdef REG_DESLOC_BURST_EN
        lit("zero_len_done", {7'd0, done}, 8'h01);
`else
        lit("nb_zero_len_done", {7'd0, done}, 8'h00);
`endif
        drive(3'd0, 1'b0, 8'h00, 4'd0); step();
        lit("zero_len_done_clear", {7'd0, done}, 8'h00);

        // Burst longer than WIDTH fills with serial_in history.
        drive(3'd3, 1'b0, 8'h00, 4'd0); step();
        drive(3'd7, 1'b1, 8'h00, 4'd10); step();
        drive(3'd0, 1'b1, 8'h00, 4'd0);
        for (int i = 0; i < 10; i++) step();
`ifdef REG_DESLOC_BURST_EN
        lit("long_burst_out", out, 8'hFF);
        lit("long_burst_done", {7'd0, done}, 8'h01);
`else
        lit("nb_long_out", out, 8'h00);
`endif

`ifndef REG_DESLOC_BURST_EN
        drive(3'd3, 1'b0, 8'h5A, 4'd0); step();
        drive(3'd7, 1'b1, 8'h00, 4'd3);
        for (int i = 0; i < 4; i++) step();
        lit("nb_op7_x4_out", out, 8'h5A);
        lit("nb_op7_x4_busy", {7'd0, busy}, 8'h00);
        lit("nb_op7_x4_done", {7'd0, done}, 8'h00);
`endif

        step();
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_desloc_n.md
REG_DESLOC_N -- requirements
Module: reg_desloc_n

Interface
REQ-001 Parameter WIDTH, 8, register width in bits; SHALL be legal for any value >= 2.
REQ-002 Parameter RESET_VAL, all zeros, WIDTH-bit value loaded into the register on reset.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  clock enable; low SHALL freeze all state, including the burst counter.
REQ-006 Port op  input  3  operation select, decoded per REQ-011.
REQ-007 Port serial_in  input  1  bit shifted into the register on shift operations.
REQ-008 Port parallel_in  input  WIDTH  parallel load data.
REQ-009 Port burst_len  input  $clog2(WIDTH)+1  number of right shifts for a burst operation.
REQ-010 Ports out (output, WIDTH, register contents), serial_out (output, 1, equal to out[0]), busy (output, 1, burst in progress), done (output, 1, one-cycle burst-complete pulse).

Function
REQ-011 In IDLE with en=1, op SHALL act at the rising edge: 000 hold; 001 shift right, serial_in into MSB; 010 shift left, serial_in into LSB; 011 load parallel_in; 100 rotate right; 101 rotate left; 110 arithmetic shift right (MSB replicated); 111 start burst.
REQ-012 Every operation except the burst SHALL take effect with 1-cycle latency: out updates at the edge where op is sampled.
REQ-013 The FSM SHALL have exactly two states, IDLE and BURST; the reset state is IDLE.
REQ-014 IDLE->BURST on op=111, en=1, burst_len>0: the edge SHALL capture burst_len into a down-counter, leave out unchanged, and set busy=1.
REQ-015 In BURST with en=1, each edge SHALL shift right with serial_in into the MSB and decrement the counter; the edge that shifts with counter=1 SHALL return to IDLE, clear busy, and set done=1 for exactly the following cycle.
REQ-016 With op=111, en=1 and burst_len=0, the FSM SHALL stay in IDLE, leave out unchanged, and pulse done for one cycle.
REQ-017 In BURST, op, parallel_in and burst_len SHALL be ignored; busy SHALL be high for exactly burst_len enabled cycles.
REQ-018 A burst_len greater than WIDTH SHALL still perform burst_len shifts, so the register fills entirely with serial_in history.
REQ-019 done SHALL be 0 except during the single pulse; a new op=111 on the cycle done is high SHALL start a new burst normally.

Reset
REQ-020 reset=1 at a rising edge SHALL force out=RESET_VAL, busy=0, done=0, state=IDLE and counter=0, regardless of en or op.
REQ-021 Reset SHALL take priority mid-burst: the burst is aborted with no done pulse.
REQ-022 Outputs SHALL change only on clock edges; reset SHALL have no asynchronous effect.

Configuration
REQ-023 Macro REG_DESLOC_BURST_EN defined: the burst logic of REQ-013..REQ-019 SHALL be compiled in.
REQ-024 Macro REG_DESLOC_BURST_EN undefined: op 111 SHALL act as hold, busy and done SHALL be tied to 0, and no FSM or counter SHALL be synthesised; all other operations are unchanged.

Verification (WIDTH=8, REG_DESLOC_BURST_EN defined unless stated)
REQ-025 Reset for 1 edge -> out=0x00, busy=0, done=0, serial_out=0.
REQ-026 op=011, parallel_in=0xA5 -> out=0xA5; then op=100 -> 0xD2; then op=101 -> 0xA5; then op=110 twice from 0x80 -> 0xE0.
REQ-027 From 0x00, op=010, serial_in=1 for 3 edges -> 0x07; en=0 for 2 edges -> holds 0x07; op=001, serial_in=0 -> 0x03, serial_out=1.
REQ-028 out=0xF0, op=111, burst_len=3, serial_in=0 -> busy high 3 cycles, out 0x78, 0x3C, 0x1E; done high for the single cycle after, op changes during the burst ignored.
REQ-029 Burst with burst_len=5, reset asserted after 2 shifts -> out=0x00, busy=0, no done pulse; op=111 with burst_len=0 -> done pulse only, out unchanged.
REQ-030 Build without REG_DESLOC_BURST_EN: op=111 from 0x5A for 4 edges -> out stays 0x5A, busy=0, done=0.
